// File: rtl/fir8_mac_sequencer_if.sv
// Handshake, coefficient and multiplier bundle for the
// time-multiplexed 8-tap FIR sequencer.
interface fir8_mac_sequencer_if #(
  parameter int N     = 8,
  parameter int ACC_W = 2*N+3
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [N-1:0]     in_data;
  logic                    coef_we;
  logic [2:0]              coef_addr;
  logic signed [N-1:0]     coef_data;
  logic signed [N-1:0]     mult_a;
  logic signed [N-1:0]     mult_b;
  logic signed [2*N-1:0]   mult_p;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    busy;

  modport master (
    output in_valid, in_data,
    output coef_we, coef_addr, coef_data,
    output mult_p, out_ready,
    input  in_ready, mult_a, mult_b,
    input  out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data,
    input  coef_we, coef_addr, coef_data,
    input  mult_p, out_ready,
    output in_ready, mult_a, mult_b,
    output out_valid, out_data, busy
  );
endinterface

// File: rtl/fir8_mac_sequencer.sv
// 8-tap FIR controller: owns delay line and coefficients, drives an
// external multiplier one tap per cycle and accumulates the sum.
module fir8_mac_sequencer #(
  parameter int N     = 8,
  parameter int ACC_W = 2*N+3
) (
  input logic                  clk,
  input logic                  rst,
  fir8_mac_sequencer_if.slave  bus
);
  localparam int TAPS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic signed [N-1:0]     x [TAPS];
  logic signed [N-1:0]     c [TAPS];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] out_q;
  logic signed [ACC_W-1:0] prod_ext;
  logic [2:0]              cnt;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    busy_q;

  assign prod_ext = {{(ACC_W-2*N){bus.mult_p[2*N-1]}}, bus.mult_p};

  // Operands are only presented while sequencing taps
  always_comb begin
    bus.mult_a = '0;
    bus.mult_b = '0;
    if (state == MAC) begin
      bus.mult_a = x[cnt];
      bus.mult_b = c[cnt];
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      out_q       <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.coef_we)
            c[bus.coef_addr] <= bus.coef_data;
          if (bus.in_valid) begin
            for (int k = TAPS-1; k > 0; k--)
              x[k] <= x[k-1];
            x[0]       <= bus.in_data;
            acc        <= '0;
            cnt        <= '0;
            state      <= MAC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            out_q       <= acc + prod_ext;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir8_mac_sequencer.sv
// Directed and randomized bench for fir8_mac_sequencer against a
// dot-product reference over a sample history queue.
module tb_fir8_mac_sequencer;
  localparam int N     = 8;
  localparam int ACC_W = 2*N+3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fir8_mac_sequencer_if #(.N(N), .ACC_W(ACC_W)) bus ();

  fir8_mac_sequencer #(.N(N), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // external combinational multiplier
  assign bus.mult_p = bus.mult_a * bus.mult_b;

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int hist[$];
  int cm[8];
  integer last_out;

  task automatic check(input string tag, input integer got,
                       input integer exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_y();
    int s = 0;
    foreach (hist[k]) s += hist[k] * cm[k];
    return s;
  endfunction

  function automatic void model_clear();
    hist = {};
    foreach (cm[k]) cm[k] = 0;
  endfunction

  task automatic push(input int s);
    hist.push_front(s);
    if (hist.size() > 8) void'(hist.pop_back());
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.coef_we   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_data", $signed(bus.out_data), 0);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic write_coef(input int a, input int d);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'(a);
    bus.coef_data = 8'(d);
    @(negedge clk);
    bus.coef_we = 1'b0;
    cm[a] = d;
  endtask

  // Caller is at a negedge; returns at a negedge.
  task automatic send(input int s, input int hold = 0,
                      input bit pend = 0, input int pd = 0,
                      input bit midw = 0, input bit abort = 0,
                      input bit wc = 0, input int wca = 0,
                      input int wcd = 0);
    int n;
    int exp;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(s);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    if (wc) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = 3'(wca);
      bus.coef_data = 8'(wcd);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    if (wc) cm[wca] = wcd;
    push(s);
    exp = ref_y();
    check("busy_mac", bus.busy, 1);
    check("in_ready_mac", bus.in_ready, 0);
    check("mult_a_tap0", $signed(bus.mult_a), s);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      if (abort && n == 4) begin
        rst = 1'b1;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_mult_a", $signed(bus.mult_a), 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      if (midw && n == 3) begin
        bus.coef_we   = 1'b1;
        bus.coef_addr = 3'd0;
        bus.coef_data = 8'sd50;
      end
      if (midw && n == 4) bus.coef_we = 1'b0;
      @(negedge clk);
      n++;
    end
    bus.coef_we = 1'b0;
    check("latency", n, 8);
    last_out = $signed(bus.out_data);
    check("out_data", last_out, exp);
    check("mult_a_done", $signed(bus.mult_a), 0);
    if (pend) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(pd);
    end
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", $signed(bus.out_data), exp);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_out_valid", bus.out_valid, 0);
    check("post_in_ready", bus.in_ready, 1);
    check("post_busy", bus.busy, 0);
  endtask

  int imp[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0, 0, 0};
  int mix[8]  = '{127, -128, 1, -1, 0, 0, 0, 0};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.out_ready = 1'b0;
    last_out      = 0;
    @(negedge clk);
    do_reset();

    // impulse response
    for (int k = 0; k < 8; k++) write_coef(k, k+1);
    for (int i = 0; i < 12; i++) begin
      send(.s(i == 0 ? 1 : 0));
      check("impulse_tab", last_out, imp[i]);
    end

    // extremes
    do_reset();
    for (int k = 0; k < 8; k++) write_coef(k, -128);
    for (int i = 0; i < 8; i++) begin
      send(.s(-128));
      if (i == 0) check("extreme_1st", last_out, 16384);
    end
    check("extreme_8th", last_out, 131072);

    // mixed sign
    do_reset();
    for (int k = 0; k < 8; k++) write_coef(k, mix[k]);
    send(.s(3));
    check("mixed_1", last_out, 381);
    send(.s(-5));
    check("mixed_2", last_out, -1019);

    // backpressure with a pending sample held off until IDLE
    send(.s(7), .hold(6), .pend(1), .pd(9));
    send(.s(9));

    // coefficient write during MAC is dropped
    send(.s(11), .midw(1));
    send(.s(-2));

    // coefficient write coinciding with accept is used immediately
    send(.s(4), .wc(1), .wca(0), .wcd(-7));

    // reset mid-MAC, then impulse with reloaded coefficients
    send(.s(1), .abort(1));
    for (int k = 0; k < 8; k++) write_coef(k, k+1);
    for (int i = 0; i < 12; i++) begin
      send(.s(i == 0 ? 1 : 0));
      check("impulse2_tab", last_out, imp[i]);
    end

    // randomized
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 8; k++)
        write_coef(k, int'($urandom_range(0, 255)) - 128);
      for (int i = 0; i < 10; i++)
        send(.s(int'($urandom_range(0, 255)) - 128),
             .hold(int'($urandom_range(0, 2))));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fir8_mac_sequencer.md
# fir8_mac_sequencer

Time-multiplexed controller for the 8-tap FIR filter. It owns the sample delay line and the coefficient bank, and sequences one shared combinational signed multiplier through all 8 taps, one tap per cycle. It accumulates the products and presents one filtered output per accepted input sample over valid/ready handshakes. It sits between the sample source and the filter output sink; the multiplier instance lives outside this block, connected via the mult_* ports.

## Interface
- N, default 8: sample and coefficient width (two's complement).
- TAPS, fixed at 8: number of taps. Not a free parameter; the counter and address are 3 bits.
- ACC_W, default 2*N+3 (19): accumulator and output width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  N  signed input sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  3  coefficient index (tap k).
- coef_data  in  N  signed coefficient value.
- mult_a  out  N  multiplier operand A (sample).
- mult_b  out  N  multiplier operand B (coefficient).
- mult_p  in  2N  signed product from the multiplier, combinational, same cycle.
- out_valid  out  1  filtered result valid.
- out_ready  in  1  sink accepts the result.
- out_data  out  ACC_W  signed filter output, y = sum over k=0..7 of x[k]*c[k].
- busy  out  1  high in MAC and DONE.

## Operation
- Storage:
  - Delay line x[0..7]; x[0] is the newest sample.
  - Coefficient bank c[0..7].
  - Accumulator acc (ACC_W bits).
  - Tap counter cnt (3 bits).
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: x[k] <= x[k-1] for k=7..1, x[0] <= in_data, acc <= 0, cnt <= 0, next state MAC.
- MAC:
  - mult_a = x[cnt], mult_b = c[cnt].
  - Each edge: acc <= acc + sign_extend(mult_p, ACC_W), cnt <= cnt+1.
  - At the edge with cnt==7: out_data <= acc + sext(mult_p), next state DONE.
- DONE:
  - out_valid=1, out_data held stable.
  - On out_ready: next state IDLE.
- mult_a and mult_b are 0 in IDLE and DONE.
- Coefficient writes:
  - Honoured only in IDLE: c[coef_addr] <= coef_data.
  - coef_we in MAC or DONE is silently dropped.
  - In IDLE, simultaneous coef_we and in_valid: both take effect at the same edge. The new coefficient is used by the MAC pass that starts on that edge.
- Arithmetic:
  - All operands are two's complement.
  - ACC_W = 2N+3 guarantees no overflow. Worst case is 8 × (−128 × −128) = 131072, which fits in 19-bit signed.
  - No saturation and no rounding.
- busy = (state != IDLE).
- Reset (asynchronous, any state, including mid-MAC):
  - state=IDLE; x[], c[], acc, cnt and out_data all 0.
  - out_valid=0, in_ready=1 (combinational from IDLE), mult_a=mult_b=0, busy=0.
  - Any partial sum is discarded; no output is produced for an interrupted sample.

## Timing
- Accept edge E (in_valid & in_ready in IDLE). MAC occupies the cycles between edges E and E+8.
- out_valid rises after edge E+8: 8-cycle latency from the accept edge.
- With out_ready held high, DONE lasts 1 cycle and IDLE is re-entered after edge E+9.
- The next accept is possible at edge E+10. Peak throughput is 1 sample per 10 cycles.
- in_ready is 0 for the whole of MAC and DONE. The source must hold in_data and in_valid until accepted.
- Backpressure: DONE persists indefinitely while out_ready=0, with out_data stable.
- in_valid arriving in DONE is not accepted until IDLE.
- mult_p is sampled at the same edge as the operands are presented. The multiplier must settle within one clock period.

## Test plan
- Impulse response: load c[k]=k+1 for k=0..7, feed 1 then eleven 0s → outputs 1,2,3,4,5,6,7,8,0,0,0,0.
- Extremes: all c[k]=−128, feed eight samples of −128 → the 8th output is 131072 (0x20000); the 1st output is 16384.
- Mixed sign: c = {127,−128,1,−1,0,0,0,0}, feed 3 then −5 → outputs 381, −1019.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid → out_data is stable, in_ready=0 and a pending in_valid is not accepted. Release out_ready → one transfer, then the accept happens 1 cycle later.
- Coefficient write during MAC: write c[0]=50 at cnt=3 → the write is ignored, and the current and next outputs use the old c[0].
- Reset at cnt=4 → next cycle out_valid=0, in_ready=1, busy=0. A subsequent impulse with reloaded coefficients reproduces the impulse-test sequence.
